temp_scan_sequencer: RTL and testbench

TEMP_SCAN_SEQUENCER -- requirements
Module: temp_scan_sequencer

---
 rtl/temp_scan_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_temp_scan_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_scan_sequencer.sv
// Round-robin temperature scan over four ADC channels: tracks the hottest valid
// reading per round, flags out-of-range/silent channels, and latches shutdown.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for scan_en
// START | one-cycle conversion request on channel ch
// WAIT  | waiting for adc_done, bounded by TIMEOUT cycles
// STORE | classify captured reading, update running max / fault flag
// END   | publish round result, pulse scan_done
// GAP   | GAP_CYCLES idle cycles between rounds
// HALT  | over-temperature shutdown, absorbing until rst
module temp_scan_sequencer #(
  parameter int unsigned NUM_CH        = 4,
  parameter logic [7:0]  MIN_TEMP      = 8'b01100011,
  parameter logic [7:0]  ALARM_TEMP    = 8'b11001000,
  parameter logic [7:0]  SHUTDOWN_TEMP = 8'b11111001,
  parameter int unsigned TIMEOUT       = 16,
  parameter int unsigned GAP_CYCLES    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic       adc_start,
  output logic [1:0] adc_ch,
  output logic [7:0] max_temp,
  output logic [1:0] max_ch,
  output logic       alarm,
  output logic       shutdown,
  output logic [3:0] fault,
  output logic       scan_done
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0]       LAST_CH  = 2'(NUM_CH - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_STORE,
    S_END,
    S_GAP,
    S_HALT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]       ch;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       adc_cap;
  logic [7:0]       run_max;
  logic [1:0]       run_ch;

  logic to_hit;
  logic gap_hit;
  logic last_ch;
  logic cap_hot;
  logic cap_low;

  assign to_hit  = (to_cnt == '0);
  assign gap_hit = (gap_cnt == '0);
  assign last_ch = (ch == LAST_CH);
  assign cap_hot = (adc_cap > SHUTDOWN_TEMP);
  assign cap_low = (adc_cap <= MIN_TEMP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // adc_done takes priority over the timeout on the last WAIT cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (scan_en) state_nxt = S_START;
      end
      S_START: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (adc_done) begin
          state_nxt = S_STORE;
        end else if (to_hit) begin
          state_nxt = last_ch ? S_END : S_START;
        end
      end
      S_STORE: begin
        if (cap_hot) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = last_ch ? S_END : S_START;
        end
      end
      S_END: begin
        state_nxt = S_GAP;
      end
      S_GAP: begin
        if (gap_hit) state_nxt = scan_en ? S_START : S_IDLE;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    adc_start = (state == S_START);
    scan_done = (state == S_END);
    adc_ch    = ch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch       <= '0;
      to_cnt   <= '0;
      gap_cnt  <= '0;
      adc_cap  <= '0;
      run_max  <= '0;
      run_ch   <= '0;
      max_temp <= '0;
      max_ch   <= '0;
      alarm    <= 1'b0;
      shutdown <= 1'b0;
      fault    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ch <= '0;
        end
        S_START: begin
          to_cnt <= TO_LOAD;
        end
        S_WAIT: begin
          if (adc_done) begin
            adc_cap <= adc_data;
          end else if (to_hit) begin
            fault[ch] <= 1'b1;
            if (!last_ch) ch <= ch + 2'd1;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        S_STORE: begin
          if (cap_hot) begin
            shutdown <= 1'b1;
            alarm    <= 1'b0;
          end else begin
            if (cap_low) begin
              fault[ch] <= 1'b1;
            end else begin
              fault[ch] <= 1'b0;
              // strict compare so ties keep the lower channel
              if (adc_cap > run_max) begin
                run_max <= adc_cap;
                run_ch  <= ch;
              end
            end
            if (!last_ch) ch <= ch + 2'd1;
          end
        end
        S_END: begin
          max_temp <= run_max;
          max_ch   <= run_ch;
          alarm    <= (run_max > ALARM_TEMP);
          run_max  <= '0;
          run_ch   <= '0;
          ch       <= '0;
          gap_cnt  <= GAP_LOAD;
        end
        S_GAP: begin
          if (!gap_hit) gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_scan_sequencer.sv
// Directed bench for temp_scan_sequencer: table of full scan rounds plus
// hand-written shutdown, scan_en drop and reset-in-WAIT sequences.
module tb_temp_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_en;
  logic       adc_done;
  logic [7:0] adc_data;
  logic       adc_start;
  logic [1:0] adc_ch;
  logic [7:0] max_temp;
  logic [1:0] max_ch;
  logic       alarm;
  logic       shutdown;
  logic [3:0] fault;
  logic       scan_done;

  int checks   = 0;
  int failures = 0;

  temp_scan_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .scan_en  (scan_en),
    .adc_done (adc_done),
    .adc_data (adc_data),
    .adc_start(adc_start),
    .adc_ch   (adc_ch),
    .max_temp (max_temp),
    .max_ch   (max_ch),
    .alarm    (alarm),
    .shutdown (shutdown),
    .fault    (fault),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] rd;
    logic [3:0]      drop;
    logic [4:0]      lat;
    logic [7:0]      exp_max;
    logic [1:0]      exp_ch;
    logic            exp_alarm;
    logic [3:0]      exp_fault;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mkv(input logic [7:0] d0, d1, d2, d3, input logic [3:0] drop,
                               input logic [4:0] lat, input logic [7:0] mx, input logic [1:0] mc,
                               input logic al, input logic [3:0] fl);
    vec_t v;
    v.rd        = {d3, d2, d1, d0};
    v.drop      = drop;
    v.lat       = lat;
    v.exp_max   = mx;
    v.exp_ch    = mc;
    v.exp_alarm = al;
    v.exp_fault = fl;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (adc_start !== 1'b1 && n < 60);
    if (adc_start !== 1'b1) chk("adc_start_seen", 32'(adc_start), 32'd1);
  endtask

  task automatic wait_scan_done();
    int n;
    n = 0;
    while (scan_done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("scan_done_seen", 32'(scan_done), 32'd1);
  endtask

  // adc_done lands in the lat-th WAIT cycle after the START cycle
  task automatic feed(input logic [7:0] d, input int lat);
    repeat (lat) tick();
    adc_done = 1'b1;
    adc_data = d;
    tick();
    adc_done = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".adc_start"}, 32'(adc_start), 32'd0);
    chk({tag, ".adc_ch"},    32'(adc_ch),    32'd0);
    chk({tag, ".max_temp"},  32'(max_temp),  32'd0);
    chk({tag, ".max_ch"},    32'(max_ch),    32'd0);
    chk({tag, ".alarm"},     32'(alarm),     32'd0);
    chk({tag, ".shutdown"},  32'(shutdown),  32'd0);
    chk({tag, ".fault"},     32'(fault),     32'd0);
    chk({tag, ".scan_done"}, 32'(scan_done), 32'd0);
  endtask

  task automatic count_starts(input int cycles, output int starts);
    starts = 0;
    repeat (cycles) begin
      tick();
      if (adc_start === 1'b1) starts++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int starts;
    int dones;
    logic [7:0] d34 [4];

    vecs[0] = mkv(8'h70, 8'hC9, 8'h80, 8'h90, 4'b0000, 5'd3,  8'hC9, 2'd1, 1'b1, 4'b0000);
    vecs[1] = mkv(8'h70, 8'h50, 8'h80, 8'h90, 4'b0000, 5'd3,  8'h90, 2'd3, 1'b0, 4'b0010);
    vecs[2] = mkv(8'h70, 8'h90, 8'h80, 8'h90, 4'b0000, 5'd3,  8'h90, 2'd1, 1'b0, 4'b0000);
    vecs[3] = mkv(8'h70, 8'h75, 8'h00, 8'h72, 4'b0100, 5'd3,  8'h75, 2'd1, 1'b0, 4'b0100);
    vecs[4] = mkv(8'h63, 8'h64, 8'hC8, 8'h60, 4'b0000, 5'd3,  8'hC8, 2'd2, 1'b0, 4'b1001);
    vecs[5] = mkv(8'h10, 8'h00, 8'h63, 8'h20, 4'b0000, 5'd3,  8'h00, 2'd0, 1'b0, 4'b1111);
    vecs[6] = mkv(8'h99, 8'h00, 8'h98, 8'h00, 4'b1010, 5'd16, 8'h99, 2'd0, 1'b0, 4'b1010);
    vecs[7] = mkv(8'hF9, 8'h80, 8'hF9, 8'h10, 4'b0000, 5'd2,  8'hF9, 2'd0, 1'b1, 4'b1000);

    rst      = 1'b1;
    scan_en  = 1'b0;
    adc_done = 1'b0;
    adc_data = 8'h00;
    repeat (2) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_no_start", 32'(adc_start), 32'd0);

    scan_en = 1'b1;
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < 4; c++) begin
        wait_start(n);
        chk($sformatf("v%0d.c%0d.adc_ch", v, c), 32'(adc_ch), 32'(c));
        if (c == 0) begin
          chk($sformatf("v%0d.gap_len", v), 32'(n), (v == 0) ? 32'd1 : 32'd8);
        end else begin
          chk($sformatf("v%0d.c%0d.start_delay", v, c), 32'(n),
              vecs[v].drop[c-1] ? 32'd17 : 32'd1);
        end
        if (!vecs[v].drop[c]) feed(vecs[v].rd[c], int'(vecs[v].lat));
      end
      wait_scan_done();
      tick();
      chk($sformatf("v%0d.scan_done_width", v), 32'(scan_done), 32'd0);
      chk($sformatf("v%0d.max_temp", v), 32'(max_temp), 32'(vecs[v].exp_max));
      chk($sformatf("v%0d.max_ch", v),   32'(max_ch),   32'(vecs[v].exp_ch));
      chk($sformatf("v%0d.alarm", v),    32'(alarm),    32'(vecs[v].exp_alarm));
      chk($sformatf("v%0d.fault", v),    32'(fault),    32'(vecs[v].exp_fault));
      chk($sformatf("v%0d.shutdown", v), 32'(shutdown), 32'd0);
    end

    // over-temperature on ch0 of the next round
    wait_start(n);
    chk("sd.gap_len", 32'(n), 32'd8);
    feed(8'hFA, 3);
    tick();
    chk("sd.shutdown", 32'(shutdown), 32'd1);
    chk("sd.alarm",    32'(alarm),    32'd0);
    chk("sd.max_temp", 32'(max_temp), 32'hF9);
    chk("sd.fault",    32'(fault),    32'b1000);
    starts = 0;
    dones  = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) begin
        adc_done = 1'b1;
        adc_data = 8'h80;
      end
      tick();
      adc_done = 1'b0;
      if (adc_start === 1'b1) starts++;
      if (scan_done === 1'b1) dones++;
    end
    chk("halt.starts",    32'(starts),   32'd0);
    chk("halt.scan_done", 32'(dones),    32'd0);
    chk("halt.shutdown",  32'(shutdown), 32'd1);
    chk("halt.max_temp",  32'(max_temp), 32'hF9);
    chk("halt.fault",     32'(fault),    32'b1000);
    rst     = 1'b1;
    scan_en = 1'b0;
    tick();
    rst = 1'b0;
    check_zero("halt_rst");
    count_starts(20, starts);
    chk("halt_rst.starts", 32'(starts), 32'd0);

    // scan_en dropped during ch1 WAIT
    d34[0] = 8'h80;
    d34[1] = 8'hD0;
    d34[2] = 8'h70;
    d34[3] = 8'h90;
    scan_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      wait_start(n);
      chk($sformatf("drop.c%0d.adc_ch", c), 32'(adc_ch), 32'(c));
      if (c == 0) chk("drop.idle_start", 32'(n), 32'd1);
      if (c == 1) begin
        tick();
        scan_en = 1'b0;
        feed(d34[c], 2);
      end else begin
        feed(d34[c], 3);
      end
    end
    wait_scan_done();
    tick();
    chk("drop.max_temp", 32'(max_temp), 32'hD0);
    chk("drop.max_ch",   32'(max_ch),   32'd1);
    chk("drop.alarm",    32'(alarm),    32'd1);
    chk("drop.fault",    32'(fault),    32'd0);
    count_starts(40, starts);
    chk("drop.starts", 32'(starts), 32'd0);
    scan_en = 1'b1;
    tick();
    chk("drop.restart",        32'(adc_start), 32'd1);
    chk("drop.restart_adc_ch", 32'(adc_ch),    32'd0);

    // reset while waiting, conversion result arrives one cycle late
    tick();
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    scan_en  = 1'b0;
    adc_done = 1'b1;
    adc_data = 8'hFA;
    tick();
    adc_done = 1'b0;
    check_zero("rst_wait");
    count_starts(10, starts);
    chk("rst_wait.starts",   32'(starts),   32'd0);
    chk("rst_wait.shutdown", 32'(shutdown), 32'd0);
    chk("rst_wait.max_temp", 32'(max_temp), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
